// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: bus source codes, sequencer FSM states and source validity helper
package bus_seq_pkg;

    localparam logic [4:0] SEL_NONE = 5'd0;
    localparam logic [4:0] SEL_R0  = 5'd1,  SEL_R1  = 5'd2,  SEL_R2  = 5'd3,  SEL_R3  = 5'd4;
    localparam logic [4:0] SEL_R4  = 5'd5,  SEL_R5  = 5'd6,  SEL_R6  = 5'd7,  SEL_R7  = 5'd8;
    localparam logic [4:0] SEL_R8  = 5'd9,  SEL_R9  = 5'd10, SEL_R10 = 5'd11, SEL_R11 = 5'd12;
    localparam logic [4:0] SEL_R12 = 5'd13, SEL_R13 = 5'd14, SEL_R14 = 5'd15, SEL_R15 = 5'd16;
    localparam logic [4:0] SEL_HI  = 5'd17, SEL_LO  = 5'd18, SEL_ZHI = 5'd19, SEL_ZLO = 5'd20;
    localparam logic [4:0] SEL_PC  = 5'd21, SEL_MDR = 5'd22, SEL_INPORT = 5'd23, SEL_C = 5'd24;
    localparam logic [4:0] SEL_Y   = 5'd25;
    localparam logic [4:0] SEL_MAX = SEL_Y;

    typedef enum logic [2:0] {ST_IDLE, ST_GRANT, ST_DRIVE, ST_LOAD, ST_DONE} state_t;

    function automatic logic src_valid(input logic [4:0] s);
        return (s != SEL_NONE) && (s <= SEL_MAX);
    endfunction

endpackage

// File: rtl/bus_transfer_sequencer_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first active request at or after rr_ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IW-1:0]      winner_idx
);

    logic [IW-1:0] k;

    // Scan downward so the last hit kept is the one closest to rr_ptr
    always_comb begin
        k          = '0;
        winner_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[k]) winner_idx = k;
        end
        winner = (|req) ? (NUM_REQ'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: round-robin bus transfer FSM (IDLE/GRANT/DRIVE/LOAD/DONE);
// defining BUS_SEQ_SRC_CHECK_EN adds port err and skips DRIVE/LOAD for invalid source codes
module bus_transfer_sequencer
    import bus_seq_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*5-1:0] src_sel,
    input  logic [NUM_REQ*5-1:0] dst_id,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [4:0]           select_signal,
    output logic [31:0]          dst_load,
`ifdef BUS_SEQ_SRC_CHECK_EN
    output logic                 err,
`endif
    output logic                 busy
);

    localparam int IW = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d, idx_q, idx_d, win_idx;
    logic [NUM_REQ-1:0] win_q, win_d, win_oh;
    logic [4:0]         src_q, src_d, dst_q, dst_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [4:0]         src_a [NUM_REQ];
    logic [4:0]         dst_a [NUM_REQ];
    logic               skip;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign src_a[g] = src_sel[g*5 +: 5];
        assign dst_a[g] = dst_id[g*5 +: 5];
    end

`ifdef BUS_SEQ_SRC_CHECK_EN
    assign skip = !src_valid(src_q);
`else
    assign skip = 1'b0;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    // State and captured transfer context; clear aborts any transfer at once
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            win_q    <= '0;
            src_q    <= SEL_NONE;
            dst_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            win_q    <= win_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state; the winner and its codes are latched as the request is accepted
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        win_d    = win_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = (state_q == ST_DRIVE) ? cnt_q + 2'd1 : 2'd0;
        case (state_q)
            ST_IDLE: if (|req) begin
                state_d = ST_GRANT;
                win_d   = win_oh;
                idx_d   = win_idx;
                src_d   = src_a[win_idx];
                dst_d   = dst_a[win_idx];
            end
            ST_GRANT: begin
                state_d  = skip ? ST_DONE : ST_DRIVE;
                rr_ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            ST_DRIVE: state_d = (cnt_q == 2'(SETTLE_CYCLES - 1)) ? ST_LOAD : ST_DRIVE;
            ST_LOAD:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from state so clear zeroes them without waiting for a clock
    always_comb begin
        busy          = (state_q != ST_IDLE);
        grant         = busy ? win_q : '0;
        done          = (state_q == ST_DONE) ? win_q : '0;
        select_signal = (state_q == ST_DRIVE || state_q == ST_LOAD) ? src_q : SEL_NONE;
        dst_load      = (state_q == ST_LOAD) ? (32'd1 << dst_q) : '0;
`ifdef BUS_SEQ_SRC_CHECK_EN
        err           = (state_q == ST_DONE) && skip;
`endif
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: two sequencers (settle 1 and 3) checked against a transfer-timeline model
module tb_bus_transfer_sequencer;

    localparam int N  = 4;
    localparam int SA = 1;
    localparam int SB = 3;
`ifdef BUS_SEQ_SRC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*5-1:0] src_sel = '0, dst_id = '0;
    logic [N-1:0] a_grant, a_done, b_grant, b_done;
    logic [4:0]   a_sel, b_sel;
    logic [31:0]  a_load, b_load;
    logic         a_busy, b_busy, a_err, b_err;
    logic [46:0]  obs [2];
    int n_checks = 0, n_errors = 0;

    // model: per DUT, cycle position within the current transfer (0 = idle)
    int         m_t [2] = '{0, 0};
    int         m_w [2] = '{0, 0};
    int         m_ptr [2] = '{0, 0};
    logic [4:0] m_src [2] = '{5'd0, 5'd0};
    logic [4:0] m_dst [2] = '{5'd0, 5'd0};
    bit         m_skip [2] = '{1'b0, 1'b0};

    bus_transfer_sequencer #(.NUM_REQ(N), .SETTLE_CYCLES(SA)) u_a (
        .clock(clock), .clear(clear), .req(req), .src_sel(src_sel), .dst_id(dst_id),
        .grant(a_grant), .done(a_done), .select_signal(a_sel), .dst_load(a_load),
`ifdef BUS_SEQ_SRC_CHECK_EN
        .err(a_err),
`endif
        .busy(a_busy));

    bus_transfer_sequencer #(.NUM_REQ(N), .SETTLE_CYCLES(SB)) u_b (
        .clock(clock), .clear(clear), .req(req), .src_sel(src_sel), .dst_id(dst_id),
        .grant(b_grant), .done(b_done), .select_signal(b_sel), .dst_load(b_load),
`ifdef BUS_SEQ_SRC_CHECK_EN
        .err(b_err),
`endif
        .busy(b_busy));

`ifndef BUS_SEQ_SRC_CHECK_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    always #5 clock = ~clock;

    always_comb begin
        obs[0] = {a_err, a_busy, a_grant, a_done, a_sel, a_load};
        obs[1] = {b_err, b_busy, b_grant, b_done, b_sel, b_load};
    end

    function automatic int settle(int d);
        return (d == 0) ? SA : SB;
    endfunction

    function automatic int last_of(int d);
        return m_skip[d] ? 2 : 3 + settle(d);
    endfunction

    function automatic bit bad_src(logic [4:0] s);
        return (s == 5'd0) || (s > 5'd25);
    endfunction

    function automatic int pick(int p);
        for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // expected {err, busy, grant, done, select, dst_load} from the model timeline
    function automatic logic [46:0] exp_v(int d);
        logic [46:0] v;
        int s;
        v = '0;
        s = settle(d);
        if (m_t[d] != 0) begin
            v[45]    = 1'b1;
            v[44:41] = N'(1 << m_w[d]);
            if (m_t[d] == last_of(d)) begin
                v[40:37] = N'(1 << m_w[d]);
                v[46]    = m_skip[d];
            end
            if (!m_skip[d] && m_t[d] >= 2 && m_t[d] <= 2 + s) v[36:32] = m_src[d];
            if (!m_skip[d] && m_t[d] == 2 + s) v[31:0] = 32'd1 << m_dst[d];
        end
        return v;
    endfunction

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int d = 0; d < 2; d++) begin
                m_t[d]   <= 0;
                m_ptr[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_t[d] == 0) begin
                    if (|req) begin
                        m_w[d]    <= pick(m_ptr[d]);
                        m_src[d]  <= src_sel[pick(m_ptr[d])*5 +: 5];
                        m_dst[d]  <= dst_id[pick(m_ptr[d])*5 +: 5];
                        m_skip[d] <= CHK && bad_src(src_sel[pick(m_ptr[d])*5 +: 5]);
                        m_ptr[d]  <= (pick(m_ptr[d]) + 1) % N;
                        m_t[d]    <= 1;
                    end
                end else begin
                    m_t[d] <= (m_t[d] == last_of(d)) ? 0 : m_t[d] + 1;
                end
            end
        end
    end

    task automatic test_reset;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== 47'd0) begin n_errors++; $display("FAIL reset dut%0d: got %h want 0", d, obs[d]); end
        end
        req = '1;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== 47'd0) begin n_errors++; $display("FAIL reset_hold dut%0d: got %h want 0", d, obs[d]); end
        end
        req   = '0;
        clear = 1'b1;
    endtask

    task automatic test_latency;
        logic [4:0] srcs [2] = '{5'd22, 5'd21};
        foreach (srcs[j]) begin
            int a_dn = -1, b_dn = -1, a_sc = 0, b_sc = 0, a_lc = 0, b_lc = 0;
            @(negedge clock);
            req = 4'b0001; src_sel = '0; dst_id = '0;
            src_sel[4:0] = srcs[j]; dst_id[4:0] = 5'd5;
            for (int c = 1; c <= 9; c++) begin
                @(negedge clock);
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (obs[d] !== exp_v(d)) begin n_errors++; $display("FAIL latency dut%0d c%0d: got %h want %h", d, c, obs[d], exp_v(d)); end
                end
                if (a_done == 4'b0001 && a_dn < 0) a_dn = c;
                if (b_done == 4'b0001 && b_dn < 0) b_dn = c;
                if (a_sel == srcs[j]) a_sc++;
                if (b_sel == srcs[j]) b_sc++;
                if (a_load == 32'h20) a_lc++;
                if (b_load == 32'h20) b_lc++;
                if (c == 1) req = '0;
            end
            n_checks += 6;
            if (a_dn != 4) begin n_errors++; $display("FAIL done_cycle settle1: got %0d want 4", a_dn); end
            if (b_dn != 6) begin n_errors++; $display("FAIL done_cycle settle3: got %0d want 6", b_dn); end
            if (a_sc != 2) begin n_errors++; $display("FAIL select_cycles settle1: got %0d want 2", a_sc); end
            if (b_sc != 4) begin n_errors++; $display("FAIL select_cycles settle3: got %0d want 4", b_sc); end
            if (a_lc != 1) begin n_errors++; $display("FAIL load_pulses settle1: got %0d want 1", a_lc); end
            if (b_lc != 1) begin n_errors++; $display("FAIL load_pulses settle3: got %0d want 1", b_lc); end
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] order [$];
        @(negedge clock); clear = 1'b0;
        @(negedge clock); clear = 1'b1; req = '1;
        for (int c = 0; c < 60 && order.size() < 8; c++) begin
            for (int k = 0; k < N; k++) begin
                src_sel[k*5 +: 5] = 5'($urandom_range(1, 25));
                dst_id[k*5 +: 5]  = 5'($urandom_range(0, 31));
            end
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v(d)) begin n_errors++; $display("FAIL rr dut%0d c%0d: got %h want %h", d, c, obs[d], exp_v(d)); end
            end
            if (a_done != '0) order.push_back(a_done);
        end
        n_checks++;
        if (order.size() != 8) begin n_errors++; $display("FAIL rr_count: got %0d want 8", order.size()); end
        foreach (order[i]) begin
            n_checks++;
            if (order[i] !== N'(1 << (i % N))) begin n_errors++; $display("FAIL rr_order[%0d]: got %b want %b", i, order[i], N'(1 << (i % N))); end
        end
        req = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v(d)) begin n_errors++; $display("FAIL rr_drain dut%0d c%0d: got %h want %h", d, c, obs[d], exp_v(d)); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int bad_loads = 0;
        @(negedge clock);
        req = 4'b0010; src_sel = '0; dst_id = '0;
        src_sel[9:5] = 5'd7; dst_id[9:5] = 5'd3;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v(d)) begin n_errors++; $display("FAIL abort_pre dut%0d c%0d: got %h want %h", d, c, obs[d], exp_v(d)); end
            end
            req = '0;
        end
        #2 clear = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== 47'd0) begin n_errors++; $display("FAIL async_clear dut%0d: got %h want 0", d, obs[d]); end
        end
        @(negedge clock);
        clear = 1'b1; req = '1;
        for (int k = 0; k < N; k++) src_sel[k*5 +: 5] = 5'd10 + 5'(k);
        dst_id = '0; dst_id[4:0] = 5'd6; dst_id[9:5] = 5'd3;
        @(negedge clock);
        n_checks += 2;
        if (a_grant !== 4'b0001) begin n_errors++; $display("FAIL post_clear_grant settle1: got %b want 0001", a_grant); end
        if (b_grant !== 4'b0001) begin n_errors++; $display("FAIL post_clear_grant settle3: got %b want 0001", b_grant); end
        req = '0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v(d)) begin n_errors++; $display("FAIL abort_post dut%0d c%0d: got %h want %h", d, c, obs[d], exp_v(d)); end
            end
            if (a_load[3] || b_load[3]) bad_loads++;
        end
        n_checks++;
        if (bad_loads != 0) begin n_errors++; $display("FAIL aborted_load: got %0d pulses want 0", bad_loads); end
    endtask

    task automatic test_src_change;
        int dn = 0, s9 = 0, s7 = 0;
        @(negedge clock);
        req = 4'b0100; src_sel = '0; dst_id = '0;
        src_sel[14:10] = 5'd7; dst_id[14:10] = 5'd9;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v(d)) begin n_errors++; $display("FAIL src_change dut%0d c%0d: got %h want %h", d, c, obs[d], exp_v(d)); end
            end
            if (a_done == 4'b0100) dn++;
            if (a_sel == 5'd9) s9++;
            if (a_sel == 5'd7) s7++;
            if (c == 2) begin req = '0; src_sel[14:10] = 5'd9; end
        end
        n_checks += 3;
        if (dn != 1) begin n_errors++; $display("FAIL src_change_done: got %0d want 1", dn); end
        if (s9 != 0) begin n_errors++; $display("FAIL src_change_new_code: got %0d cycles want 0", s9); end
        if (s7 != 2) begin n_errors++; $display("FAIL src_change_old_code: got %0d cycles want 2", s7); end
    endtask

    task automatic test_invalid;
        int la = 0, dn = -1;
        logic errd = 1'b0;
        @(negedge clock);
        req = 4'b0001; src_sel = '0; dst_id = '0; dst_id[4:0] = 5'd4;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v(d)) begin n_errors++; $display("FAIL invalid dut%0d c%0d: got %h want %h", d, c, obs[d], exp_v(d)); end
            end
            if (a_load != '0) la++;
            if (a_done == 4'b0001 && dn < 0) begin dn = c; errd = a_err; end
            if (c == 1) req = '0;
        end
        n_checks += 2;
        if (la != (CHK ? 0 : 1)) begin n_errors++; $display("FAIL invalid_load: got %0d want %0d", la, CHK ? 0 : 1); end
        if (dn != (CHK ? 2 : 4)) begin n_errors++; $display("FAIL invalid_done_cycle: got %0d want %0d", dn, CHK ? 2 : 4); end
`ifdef BUS_SEQ_SRC_CHECK_EN
        n_checks++;
        if (errd !== 1'b1) begin n_errors++; $display("FAIL invalid_err: got %b want 1", errd); end
`endif
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v(d)) begin n_errors++; $display("FAIL random dut%0d c%0d: got %h want %h", d, c, obs[d], exp_v(d)); end
            end
            clear   = ($urandom_range(0, 59) != 0);
            req     = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            src_sel = 20'($urandom);
            dst_id  = 20'($urandom);
        end
        clear = 1'b1; req = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v(d)) begin n_errors++; $display("FAIL random_drain dut%0d c%0d: got %h want %h", d, c, obs[d], exp_v(d)); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        #2 clear = 1'b0;
        test_reset();
        test_latency();
        test_round_robin();
        test_reset_mid();
        test_src_change();
        test_invalid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
